disk_track_writer: RTL and testbench

- Writeback engine for the floppy track buffer: the write-direction counterpart of the track loader.
- When the disk controller has modified the buffered track, it streams that track's sectors from track RAM back to the mounted image through the hps_io sd_wr / sd_buff_din interface.
- Sits beside the track loader in the emu top level and shares its track RAM (read port) and the hps_io SD channel.
- The loader must not start a read while wr_busy=1.

---
 rtl/disk_track_writer.sv | 161 ++++++++++++++++
 tb/tb_disk_track_writer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disk_track_writer.sv
// rtl/disk_track_writer.sv - floppy track buffer writeback engine
//
// Streams a modified track from track RAM back to the mounted image through
// the hps_io sd_wr / sd_buff_din channel, one 512-byte sector per sd_ack pulse.
// Optional feature macro: TRACK_WR_PROTECT_EN (adds write_protect input).
//
// Ports:
//   clk_sys, reset_n        system clock, asynchronous active-low reset
//   track                   current head track from the disk controller
//   dirty_set               pulse: controller wrote a byte into track RAM
//   flush_req               pulse: write back now if dirty
//   img_mounted             hps_io mount strobe (drops pending dirty state)
//   img_size_nz             an image is present
//   write_protect           (optional) suppress writeback, discard dirty state
//   sd_ack, sd_buff_addr    hps_io sector handshake and byte address
//   track_ram_dout          track RAM read data (1-cycle latency)
//   sd_lba, sd_wr           sector LBA and write request to hps_io
//   sd_buff_din             byte to hps_io
//   track_ram_addr          track RAM read address
//   cpu_wait                CPU stall while a flush runs
//   wr_busy                 engine not idle
//   dirty                   buffered track differs from the image
module disk_track_writer #(
  parameter int SECTORS = 13,
  parameter int TRACK_W = 6,
  parameter int LBA_W   = 32
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [TRACK_W-1:0] track,
  input  logic               dirty_set,
  input  logic               flush_req,
  input  logic               img_mounted,
  input  logic               img_size_nz,
`ifdef TRACK_WR_PROTECT_EN
  input  logic               write_protect,
`endif
  input  logic               sd_ack,
  input  logic [8:0]         sd_buff_addr,
  input  logic [7:0]         track_ram_dout,
  output logic [LBA_W-1:0]   sd_lba,
  output logic               sd_wr,
  output logic [7:0]         sd_buff_din,
  output logic [12:0]        track_ram_addr,
  output logic               cpu_wait,
  output logic               wr_busy,
  output logic               dirty
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t             state;
  logic [TRACK_W-1:0] cur_track;   // track held in RAM; frozen for the whole flush
  logic [3:0]         sec_cnt;
  logic               old_ack;
  logic               redirty;     // dirty_set seen since the flush started
  logic               abort;       // image remounted mid-flush: stop after this sector
  logic               wp;
  logic               ack_rise;
  logic               ack_fall;
  logic               trigger;
  logic               last_sec;
  logic [LBA_W-1:0]   start_lba;

`ifdef TRACK_WR_PROTECT_EN
  assign wp = write_protect;
`else
  assign wp = 1'b0;
`endif

  assign ack_rise  = sd_ack & ~old_ack;
  assign ack_fall  = ~sd_ack & old_ack;
  assign trigger   = dirty & ((track != cur_track) | flush_req);
  assign last_sec  = (sec_cnt >= 4'(SECTORS - 1));
  assign start_lba = LBA_W'(cur_track) * LBA_W'(SECTORS);

  assign track_ram_addr = {sec_cnt, sd_buff_addr};
  assign sd_buff_din    = track_ram_dout;
  assign wr_busy        = (state != IDLE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sd_lba    <= '0;
      sd_wr     <= 1'b0;
      cpu_wait  <= 1'b0;
      dirty     <= 1'b0;
      sec_cnt   <= 4'd0;
      cur_track <= '0;
      old_ack   <= 1'b0;
      redirty   <= 1'b0;
      abort     <= 1'b0;
    end else begin
      old_ack <= sd_ack;
      case (state)
        IDLE: begin
          if (img_mounted) begin
            // New image: whatever was buffered no longer belongs to it.
            dirty     <= dirty_set;
            cur_track <= track;
          end else if (trigger && img_size_nz && !wp) begin
            sec_cnt  <= 4'd0;
            sd_lba   <= start_lba;
            sd_wr    <= 1'b1;
            cpu_wait <= 1'b1;
            redirty  <= dirty_set;
            abort    <= 1'b0;
            state    <= XFER;
          end else begin
            cur_track <= track;
            if (trigger)
              dirty <= dirty_set;   // nowhere to write: discard, keep a fresh write
            else if (dirty_set)
              dirty <= 1'b1;
          end
        end

        XFER: begin
          if (dirty_set) begin
            dirty   <= 1'b1;
            redirty <= 1'b1;
          end else if (img_mounted) begin
            dirty   <= 1'b0;
            redirty <= 1'b0;
          end
          if (img_mounted)
            abort <= 1'b1;

          // Held high except for the single cycle after each sector ends.
          cpu_wait <= 1'b1;

          if (ack_rise) begin
            if (last_sec || abort)
              sd_wr <= 1'b0;
            sd_lba <= sd_lba + 1'b1;
          end

          if (ack_fall) begin
            sec_cnt  <= sec_cnt + 4'd1;
            cpu_wait <= 1'b0;
            if (!sd_wr || abort || img_mounted) begin
              sd_wr <= 1'b0;
              state <= DONE;
            end
          end
        end

        DONE: begin
          dirty     <= dirty_set | (redirty & ~img_mounted);
          cpu_wait  <= 1'b0;
          sd_wr     <= 1'b0;
          cur_track <= track;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disk_track_writer.sv
// tb/tb_disk_track_writer.sv - scoreboard bench for disk_track_writer
module tb_disk_track_writer;

  localparam int SECTORS = 13;
  localparam int TRACK_W = 6;
  localparam int LBA_W   = 32;

  logic               clk_sys = 1'b0;
  logic               reset_n = 1'b0;
  logic [TRACK_W-1:0] track = '0;
  logic               dirty_set = 1'b0;
  logic               flush_req = 1'b0;
  logic               img_mounted = 1'b0;
  logic               img_size_nz = 1'b1;
`ifdef TRACK_WR_PROTECT_EN
  logic               write_protect = 1'b0;
`endif
  logic               sd_ack = 1'b0;
  logic [8:0]         sd_buff_addr = '0;
  logic [7:0]         track_ram_dout;
  logic [LBA_W-1:0]   sd_lba;
  logic               sd_wr;
  logic [7:0]         sd_buff_din;
  logic [12:0]        track_ram_addr;
  logic               cpu_wait;
  logic               wr_busy;
  logic               dirty;

  disk_track_writer #(.SECTORS(SECTORS), .TRACK_W(TRACK_W), .LBA_W(LBA_W)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .track          (track),
    .dirty_set      (dirty_set),
    .flush_req      (flush_req),
    .img_mounted    (img_mounted),
    .img_size_nz    (img_size_nz),
`ifdef TRACK_WR_PROTECT_EN
    .write_protect  (write_protect),
`endif
    .sd_ack         (sd_ack),
    .sd_buff_addr   (sd_buff_addr),
    .track_ram_dout (track_ram_dout),
    .sd_lba         (sd_lba),
    .sd_wr          (sd_wr),
    .sd_buff_din    (sd_buff_din),
    .track_ram_addr (track_ram_addr),
    .cpu_wait       (cpu_wait),
    .wr_busy        (wr_busy),
    .dirty          (dirty)
  );

  always #5 clk_sys = ~clk_sys;

  // Track RAM model: byte = addr[7:0] ^ sector, one cycle read latency.
  logic [7:0] ram_q = '0;
  always @(posedge clk_sys) ram_q <= track_ram_addr[7:0] ^ {4'b0, track_ram_addr[12:9]};
  assign track_ram_dout = ram_q;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        chk_q[$];
  logic [31:0] exp_lba_q[$];
  logic [7:0]  exp_byte_q[$];

  localparam int S_WR = 0, S_LBA = 1, S_WAIT = 2, S_BUSY = 3, S_DIRTY = 4, S_TRK = 5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      S_WR:    return {31'b0, sd_wr};
      S_LBA:   return sd_lba;
      S_WAIT:  return {31'b0, cpu_wait};
      S_BUSY:  return {31'b0, wr_busy};
      S_DIRTY: return {31'b0, dirty};
      default: return {26'b0, dut.cur_track};
    endcase
  endfunction

  // Monitor: compares on the falling edge, away from the DUT's active edge.
  logic mon_prev_ack = 1'b0;
  logic av = 1'b0;
  logic av_d = 1'b0;
  always @(posedge clk_sys) av_d <= av;

  always @(negedge clk_sys) begin
    if (sd_ack && !mon_prev_ack) begin
      if (exp_lba_q.size() == 0) check("lba_unexpected_sector", sd_lba, 32'hFFFF_FFFF);
      else check("sector_lba", sd_lba, exp_lba_q.pop_front());
    end
    mon_prev_ack = sd_ack;
    if (av_d) begin
      if (exp_byte_q.size() == 0) check("byte_unexpected", {24'b0, sd_buff_din}, 32'hFFFF_FFFF);
      else check("sd_buff_din", {24'b0, sd_buff_din}, {24'b0, exp_byte_q.pop_front()});
    end
    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      check(c.name, probe(c.sel), c.exp);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_now(input string n, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = n;
    c.sel  = sel;
    c.exp  = v;
    chk_q.push_back(c);
  endtask

  task automatic pulse_dirty();
    dirty_set = 1'b1;
    tick();
    dirty_set = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic wait_wr(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (sd_wr !== 1'b1) begin
      tick();
      n++;
      if (n > 50) begin
        check("sd_wr_timeout", {31'b0, sd_wr}, 32'd1);
        ok = 1'b0;
        return;
      end
    end
  endtask

  // One hps_io sector: raise ack, sweep 512 addresses, drop ack.
  task automatic do_sector(input logic [31:0] lba, input int k, input bit drop_on_rise,
                           input bit more, input int dset_at, input int mount_at);
    exp_lba_q.push_back(lba);
    sd_ack = 1'b1;
    for (int a = 0; a < 512; a++) begin
      tick();
      if (a == 0) expect_now("sd_wr_after_rise", S_WR, drop_on_rise ? 32'd0 : 32'd1);
      sd_buff_addr = 9'(a);
      av = 1'b1;
      exp_byte_q.push_back(8'(a) ^ 8'(k));
      dirty_set   = (a == dset_at);
      img_mounted = (a == mount_at);
    end
    tick();
    av = 1'b0;
    sd_ack = 1'b0;
    dirty_set = 1'b0;
    img_mounted = 1'b0;
    tick();
    expect_now("cpu_wait_gap", S_WAIT, 32'd0);
    tick();
    expect_now("cpu_wait_after_gap", S_WAIT, more ? 32'd1 : 32'd0);
  endtask

  task automatic do_flush(input logic [31:0] base, input int nsec, input int dset_sec, input int mount_sec);
    bit ok;
    for (int k = 0; k < nsec; k++) begin
      wait_wr(ok);
      if (!ok) return;
      do_sector(base + 32'(k), k, (k == SECTORS - 1), (k < nsec - 1),
                (k == dset_sec) ? 100 : -1, (k == mount_sec) ? 100 : -1);
    end
    tick();
    expect_now("wr_busy_after_flush", S_BUSY, 32'd0);
    expect_now("sd_wr_after_flush", S_WR, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // Reset state, sampled while reset is still asserted.
    repeat (3) tick();
    expect_now("rst_sd_wr", S_WR, 32'd0);
    expect_now("rst_sd_lba", S_LBA, 32'd0);
    expect_now("rst_cpu_wait", S_WAIT, 32'd0);
    expect_now("rst_wr_busy", S_BUSY, 32'd0);
    expect_now("rst_dirty", S_DIRTY, 32'd0);
    expect_now("rst_cur_track", S_TRK, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Dirty track 5, move head to 6: writes LBA 65..77.
    track = 6'd5;
    tick(); tick();
    expect_now("t1_cur_track_5", S_TRK, 32'd5);
    pulse_dirty();
    expect_now("t1_dirty_set", S_DIRTY, 32'd1);
    track = 6'd6;
    tick();
    expect_now("t1_sd_wr_start", S_WR, 32'd1);
    expect_now("t1_sd_lba_start", S_LBA, 32'd65);
    expect_now("t1_cpu_wait_start", S_WAIT, 32'd1);
    expect_now("t1_wr_busy_start", S_BUSY, 32'd1);
    expect_now("t1_cur_track_held", S_TRK, 32'd5);
    do_flush(32'd65, SECTORS, -1, -1);
    expect_now("t1_final_lba", S_LBA, 32'd78);
    expect_now("t1_dirty_clear", S_DIRTY, 32'd0);
    expect_now("t1_cur_track_6", S_TRK, 32'd6);
    expect_now("t1_cpu_wait_end", S_WAIT, 32'd0);

    // Clean track change: nothing written.
    track = 6'd5;
    tick(); tick();
    track = 6'd6;
    tick();
    expect_now("t2_sd_wr", S_WR, 32'd0);
    expect_now("t2_wr_busy", S_BUSY, 32'd0);
    expect_now("t2_cur_track", S_TRK, 32'd6);
    tick();
    expect_now("t2_sd_wr_later", S_WR, 32'd0);

    // No image: flush request just drops the dirty state.
    img_size_nz = 1'b0;
    pulse_dirty();
    expect_now("t3_dirty_set", S_DIRTY, 32'd1);
    pulse_flush();
    expect_now("t3_dirty_dropped", S_DIRTY, 32'd0);
    expect_now("t3_sd_wr", S_WR, 32'd0);
    expect_now("t3_wr_busy", S_BUSY, 32'd0);
    tick();
    expect_now("t3_sd_wr_later", S_WR, 32'd0);
    img_size_nz = 1'b1;

    // dirty_set during sector 3 forces a second flush of the same track.
    track = 6'd5;
    tick(); tick();
    expect_now("t4_cur_track_5", S_TRK, 32'd5);
    pulse_dirty();
    pulse_flush();
    expect_now("t4_sd_wr_start", S_WR, 32'd1);
    expect_now("t4_sd_lba_start", S_LBA, 32'd65);
    do_flush(32'd65, SECTORS, 3, -1);
    expect_now("t4_dirty_survives", S_DIRTY, 32'd1);
    pulse_flush();
    expect_now("t4_reflush_lba", S_LBA, 32'd65);
    do_flush(32'd65, SECTORS, -1, -1);
    expect_now("t4_dirty_clear", S_DIRTY, 32'd0);
    expect_now("t4_final_lba", S_LBA, 32'd78);

    // Mount strobe: clears dirty in IDLE; in XFER ends after current sector.
    pulse_dirty();
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    expect_now("t5_mount_clears_dirty", S_DIRTY, 32'd0);
    pulse_dirty();
    pulse_flush();
    do_flush(32'd65, 3, -1, 2);
    expect_now("t5_abort_lba", S_LBA, 32'd68);
    expect_now("t5_abort_dirty", S_DIRTY, 32'd0);

`ifdef TRACK_WR_PROTECT_EN
    write_protect = 1'b1;
    pulse_dirty();
    track = 6'd6;
    tick();
    expect_now("wp_no_sd_wr", S_WR, 32'd0);
    expect_now("wp_dirty_cleared", S_DIRTY, 32'd0);
    tick();
    expect_now("wp_not_busy", S_BUSY, 32'd0);
    write_protect = 1'b0;
    track = 6'd5;
    tick(); tick();
`endif

    // Reset in the middle of sector 7.
    pulse_dirty();
    pulse_flush();
    for (int k = 0; k < 7; k++) begin
      wait_wr(ok);
      if (ok) do_sector(32'd65 + 32'(k), k, 1'b0, 1'b1, -1, -1);
    end
    wait_wr(ok);
    exp_lba_q.push_back(32'd72);
    sd_ack = 1'b1;
    for (int a = 0; a < 100; a++) begin
      tick();
      sd_buff_addr = 9'(a);
      av = 1'b1;
      exp_byte_q.push_back(8'(a) ^ 8'd7);
    end
    tick();
    av = 1'b0;
    sd_ack = 1'b0;
    reset_n = 1'b0;
    expect_now("t6_rst_sd_wr", S_WR, 32'd0);
    expect_now("t6_rst_cpu_wait", S_WAIT, 32'd0);
    expect_now("t6_rst_wr_busy", S_BUSY, 32'd0);
    expect_now("t6_rst_dirty", S_DIRTY, 32'd0);
    expect_now("t6_rst_sd_lba", S_LBA, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    expect_now("t6_post_cur_track", S_TRK, 32'd5);
    expect_now("t6_post_sd_wr", S_WR, 32'd0);
    tick(); tick();

    check("lba_queue_drained", 32'(exp_lba_q.size()), 32'd0);
    check("byte_queue_drained", 32'(exp_byte_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
